// File: rtl/bcd_to_bin_encoder_if.sv
// Handshake and data bundle for the BCD-to-binary encoder: start/digits/sign in,
// busy/done/err and the result byte pair out.
interface bcd_to_bin_encoder_if;
  logic       start;
  logic [3:0] num_C3;
  logic [3:0] num_C2;
  logic [3:0] num_C1;
  logic [3:0] num_C0;
  logic       sign;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] data_outH;
  logic [7:0] data_outL;

  modport master (
    output start, num_C3, num_C2, num_C1, num_C0, sign,
    input  busy, done, err, data_outH, data_outL
  );

  modport slave (
    input  start, num_C3, num_C2, num_C1, num_C0, sign,
    output busy, done, err, data_outH, data_outL
  );
endinterface

// File: rtl/bcd_to_bin_encoder.sv
// Sequential BCD-to-two's-complement encoder: accumulates one digit per clock
// (MSD first, acc = acc*10 + digit), then applies the sign and registers the byte pair.
module bcd_to_bin_encoder #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [15:0] ERR_CODE   = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_to_bin_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] IDX_MSD = 2'(NUM_DIGITS - 1);

  state_t      state;
  logic [3:0]  digit_l [4];
  logic        sign_l;
  logic [15:0] acc;
  logic [1:0]  idx;
  logic        err_i;
  logic [3:0]  cur_digit;
  logic [15:0] res_c;

  // Multiply by ten as shift-and-add, then add the incoming digit.
  function automatic logic [15:0] mac10(input logic [15:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {12'd0, d};
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  // Widened by one bit so negating the magnitude is a plain signed negate; wraps mod 2^16.
  function automatic logic [15:0] apply_sign(input logic [15:0] mag, input logic neg);
    logic signed [16:0] s;
    s = $signed({1'b0, mag});
    if (neg) s = -s;
    return s[15:0];
  endfunction

  always_comb begin
    cur_digit = digit_l[idx];
    res_c     = err_i ? ERR_CODE : apply_sign(acc, sign_l);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.data_outH <= 8'h00;
      bus.data_outL <= 8'h00;
      acc           <= 16'h0000;
      idx           <= 2'd0;
      err_i         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            digit_l[3] <= bus.num_C3;
            digit_l[2] <= bus.num_C2;
            digit_l[1] <= bus.num_C1;
            digit_l[0] <= bus.num_C0;
            sign_l     <= bus.sign;
            acc        <= 16'h0000;
            idx        <= IDX_MSD;
            err_i      <= 1'b0;
            bus.busy   <= 1'b1;
            state      <= ACC;
          end
        end
        // ---- accumulate: one digit per clock, stop after the units digit ----
        ACC: begin
          acc   <= mac10(acc, cur_digit);
          err_i <= err_i | digit_bad(cur_digit);
          if (idx == 2'd0) begin
            state <= FIN;
          end else begin
            idx <= idx - 2'd1;
          end
        end
        // ---- finish: sign/error select, register result, pulse done ----
        FIN: begin
          bus.data_outH <= res_c[15:8];
          bus.data_outL <= res_c[7:0];
          bus.err       <= err_i;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Digit registers are data only; their content is irrelevant until a start latches them.
  logic unused_ok;
  assign unused_ok = &{1'b0, digit_l[3][0]};

endmodule

// File: tb/tb_bcd_to_bin_encoder.sv
// Directed self-checking bench for bcd_to_bin_encoder (NUM_DIGITS=4, ERR_CODE=0).
module tb_bcd_to_bin_encoder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bcd_to_bin_encoder_if bus();

  bcd_to_bin_encoder #(.NUM_DIGITS(4), .ERR_CODE(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0, input logic s);
    bus.num_C3 = d3; bus.num_C2 = d2; bus.num_C1 = d1; bus.num_C0 = d0; bus.sign = s;
  endtask

  // Pulses start, then waits for done; lat = clocks after the accepting edge (-1 on timeout).
  task automatic run_conv(input logic [3:0] d3, d2, d1, d0, input logic s,
                          output logic [15:0] res, output logic e, output int lat);
    set_digits(d3, d2, d1, d0, s);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = -1;
    res = {bus.data_outH, bus.data_outL};
    e   = bus.err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if ({bus.data_outH, bus.data_outL} !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h expected 0000", {bus.data_outH, bus.data_outL}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] res; logic e; int lat;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    set_digits(4'd7, 4'd7, 4'd7, 4'd7, 1'b1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    res = {bus.data_outH, bus.data_outL}; e = bus.err;
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++; if (res !== 16'h04D2) begin errors++; $display("FAIL basic_1234: got %h expected 04d2", res); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", e); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    repeat (3) @(negedge clk);
    checks++; if ({bus.data_outH, bus.data_outL} !== 16'h04D2) begin
      errors++; $display("FAIL basic_hold: got %h expected 04d2", {bus.data_outH, bus.data_outL}); end
  endtask

  task automatic test_signed();
    logic [15:0] res; logic e; int lat;
    run_conv(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, res, e, lat);
    checks++; if (res !== 16'hFFFF) begin errors++; $display("FAIL neg_one: got %h expected ffff", res); end
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, res, e, lat);
    checks++; if (res !== 16'hD8F1) begin errors++; $display("FAIL neg_9999: got %h expected d8f1", res); end
    run_conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, res, e, lat);
    checks++; if (res !== 16'h270F) begin errors++; $display("FAIL pos_9999: got %h expected 270f", res); end
    run_conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, res, e, lat);
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL neg_zero: got %h expected 0000", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL neg_zero_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_error();
    logic [15:0] res; logic e; int lat;
    run_conv(4'd1, 4'hA, 4'd0, 4'd0, 1'b0, res, e, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL err_done: latency got %0d expected 5", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", e); end
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL err_code: got %h expected 0000", res); end
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, res, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", e); end
    checks++; if (res !== 16'h002A) begin errors++; $display("FAIL err_after_42: got %h expected 002a", res); end
    run_conv(4'd0, 4'd0, 4'd0, 4'hF, 1'b1, res, e, lat);
    checks++; if (e !== 1'b1 || res !== 16'h0000) begin
      errors++; $display("FAIL err_units: got err=%b res=%h expected err=1 res=0000", e, res); end
  endtask

  task automatic test_back_to_back();
    int n; int t_done [2]; logic [15:0] r_done [2];
    @(negedge clk);
    n = 0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 16; t++) begin
      if (t == 1) set_digits(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
      if (t == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (n < 2) begin t_done[n] = t; r_done[n] = {bus.data_outH, bus.data_outL}; end
        n++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
    if (n >= 2) begin
      checks++; if (t_done[0] !== 5) begin errors++; $display("FAIL b2b_first_t: got %0d expected 5", t_done[0]); end
      checks++; if (t_done[1] !== 11) begin errors++; $display("FAIL b2b_second_t: got %0d expected 11", t_done[1]); end
      checks++; if (r_done[0] !== 16'h0007) begin errors++; $display("FAIL b2b_latched: got %h expected 0007", r_done[0]); end
      checks++; if (r_done[1] !== 16'h270F) begin errors++; $display("FAIL b2b_second: got %h expected 270f", r_done[1]); end
    end
  endtask

  task automatic test_start_while_busy();
    int n; logic [15:0] r;
    n = 0; r = 16'hXXXX;
    set_digits(4'd0, 4'd3, 4'd2, 4'd1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t <= 14; t++) begin
      if (t == 2) begin bus.start = 1'b1; set_digits(4'd8, 4'd8, 4'd8, 4'd8, 1'b1); end
      if (t == 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin n++; r = {bus.data_outH, bus.data_outL}; end
      @(negedge clk);
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL busy_ignore_count: got %0d expected 1", n); end
    checks++; if (r !== 16'h0141) begin errors++; $display("FAIL busy_ignore_result: got %h expected 0141", r); end
  endtask

  task automatic test_reset_mid();
    int n; logic [15:0] res; logic e; int lat;
    set_digits(4'd5, 4'd5, 4'd5, 4'd5, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.data_outH, bus.data_outL} !== 16'h0000) begin
      errors++; $display("FAIL midrst_data: got %h expected 0000", {bus.data_outH, bus.data_outL}); end
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      if (bus.done === 1'b1) n++;
      @(negedge clk);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n); end
    run_conv(4'd0, 4'd0, 4'd1, 4'd2, 1'b1, res, e, lat);
    checks++; if (res !== 16'hFFF4 || lat !== 5) begin
      errors++; $display("FAIL midrst_next: got %h lat %0d expected fff4 lat 5", res, lat); end
  endtask

  task automatic test_sweep();
    logic [15:0] res; logic e; int lat; logic [15:0] exp_v; int m;
    m = 0;
    while (m <= 9999) begin
      for (int s = 0; s < 2; s++) begin
        exp_v = (s == 1) ? 16'(0 - m) : 16'(m);
        run_conv(4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10), s[0], res, e, lat);
        checks++;
        if (res !== exp_v || e !== 1'b0 || lat !== 5) begin
          errors++;
          $display("FAIL sweep_%0d_s%0d: got %h err=%b lat=%0d expected %h err=0 lat=5", m, s, res, e, lat, exp_v);
        end
      end
      if (m == 9999) m = 10000;
      else if (m + 37 > 9999) m = 9999;
      else m = m + 37;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_error();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
